// File: rtl/rsa_decrypt_engine.sv
// RSA decryption core: m = c^d mod n by right-to-left square-and-multiply over a
// bit-serial interleaved modular multiplier (one BITS-cycle pass per modmul).
module rsa_decrypt_engine #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic [BITS-1:0] c,
  input  logic [BITS-1:0] d_key,
  input  logic [BITS-1:0] n,
  output logic [BITS-1:0] m,
  output logic            done,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [2:0] {IDLE, REDUCE, EXP, MULR, SQR, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] e_q, e_d;
  logic [BITS-1:0] n_q, n_d;
  logic [BITS-1:0] base_q, base_d;
  logic [BITS-1:0] res_q, res_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] m_q, m_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [BITS:0]   nx, ax, acc_dbl, acc_nx;

  // One interleaved step: double, reduce, conditionally add a, reduce.
  // acc < n on entry, so both intermediate values stay below 2n.
  always_comb begin
    nx      = {1'b0, n_q};
    ax      = {1'b0, a_q};
    acc_dbl = acc_q << 1;
    if (acc_dbl >= nx) acc_dbl = acc_dbl - nx;
    acc_nx  = acc_dbl + (b_q[BITS-1] ? ax : '0);
    if (acc_nx >= nx) acc_nx = acc_nx - nx;
  end

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    n_d     = n_q;
    base_d  = base_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          e_d = d_key;
          n_d = n;
          if (n < BITS'(2)) begin
            state_d = DONE;
            done_d  = 1'b1;
            m_d     = '0;
            err_d   = (n == '0);
          end else begin
            state_d = REDUCE;
            a_d     = BITS'(1);
            b_d     = c;
            acc_d   = '0;
            cnt_d   = '0;
            res_d   = BITS'(1);
          end
        end
      end
      REDUCE, MULR, SQR: begin
        acc_d = acc_nx;
        b_d   = b_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS - 1)) begin
          acc_d = '0;
          cnt_d = '0;
          if (state_q == REDUCE) begin
            base_d  = acc_nx[BITS-1:0];
            state_d = EXP;
          end else if (state_q == MULR) begin
            res_d   = acc_nx[BITS-1:0];
            a_d     = base_q;
            b_d     = base_q;
            state_d = SQR;
          end else begin
            base_d  = acc_nx[BITS-1:0];
            e_d     = e_q >> 1;
            state_d = EXP;
          end
        end
      end
      EXP: begin
        if (e_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          m_d     = res_q;
        end else if (e_q[0]) begin
          state_d = MULR;
          a_d     = res_q;
          b_d     = base_q;
        end else begin
          state_d = SQR;
          a_d     = base_q;
          b_d     = base_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      n_q     <= n_d;
      base_q  <= base_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign m    = m_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Scoreboard bench for rsa_decrypt_engine: driver pushes expected results from a
// plain-arithmetic model, a negedge monitor pops and compares on every done.
module tb_rsa_decrypt_engine;

  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            go = 1'b0;
  logic [BITS-1:0] c = '0, d_key = '0, n = '0;
  logic [BITS-1:0] m;
  logic            done, busy, err;

  rsa_decrypt_engine #(.BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .c(c), .d_key(d_key), .n(n),
    .m(m), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int err;
    int due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_m(input int cv, input int dv, input int nv);
    int r, b, e;
    if (nv < 2) return 0;
    r = 1;
    b = cv % nv;
    for (e = dv; e > 0; e = e / 2) begin
      if (e % 2 == 1) r = (r * b) % nv;
      b = (b * b) % nv;
    end
    return r;
  endfunction

  function automatic int ref_lat(input int dv, input int nv);
    int k, w;
    if (nv < 2) return 0;
    k = 0;
    w = 0;
    for (int i = 0; i < BITS; i++) begin
      if ((dv >> i) % 2 == 1) begin
        k = i + 1;
        w++;
      end
    end
    return BITS + k * (BITS + 1) + w * BITS + 1;
  endfunction

  // Monitor: every done is checked against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (prev_done) begin
      chk("done_width", int'(done), 0);
      chk("busy_after_done", int'(busy), 0);
    end
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("m", int'(m), e.m);
        chk("err", int'(err), e.err);
        chk("done_cycle", cyc, e.due);
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int cv, input int dv, input int nv, input bit push);
    exp_t e;
    wait_idle();
    go    = 1'b1;
    c     = BITS'(cv);
    d_key = BITS'(dv);
    n     = BITS'(nv);
    e.m   = ref_m(cv, dv, nv);
    e.err = (nv == 0) ? 1 : 0;
    e.due = cyc + 1 + ref_lat(dv, nv);
    if (push) q.push_back(e);
    @(negedge clk);
    go    = 1'b0;
    c     = BITS'($urandom_range(0, 15));
    d_key = BITS'($urandom_range(0, 15));
    n     = BITS'($urandom_range(0, 15));
    chk("busy_rise", int'(busy), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m", int'(m), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4, 13, 7, 1);
    issue(5, 2, 9, 1);
    issue(6, 3, 13, 1);
    issue(3, 7, 8, 1);
    issue(9, 3, 13, 1);
    issue(5, 5, 7, 1);
    issue(8, 3, 15, 1);
    issue(14, 1, 5, 1);
    issue(6, 0, 7, 1);
    issue(7, 0, 7, 1);
    issue(6, 5, 0, 1);
    issue(6, 5, 1, 1);

    // Stray go while busy must be dropped.
    issue(4, 13, 7, 1);
    repeat (3) @(negedge clk);
    go = 1'b1; c = 4'd3; d_key = 4'd1; n = 4'd11;
    @(negedge clk);
    go = 1'b0;

    // Abort mid-computation; the previous result (4) must be cleared.
    issue(6, 15, 11, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_m", int'(m), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(5, 2, 9, 1);

    for (int i = 0; i < 20; i++)
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
